// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control unit of the 8-bit processor.
// Holds the opcode and R-type function codes, ALU operation codes, PC source
// selects, the FSM state encoding and the latched instruction class, plus the
// R-type function-to-ALU lookup used by the decoder.
package cpu_pkg;

    // Major opcodes (4-bit IR opcode field)
    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_ADDI   = 4'b0100;
    localparam logic [3:0] OP_LOAD   = 4'b1011;
    localparam logic [3:0] OP_STORE  = 4'b1111;
    localparam logic [3:0] OP_BRANCH = 4'b1000;
    localparam logic [3:0] OP_JUMP   = 4'b0010;

    // R-type function code with no ALU operation behind it
    localparam logic [2:0] FN_ILLEGAL = 3'b110;

    // ALU operations referenced by non-R-type instructions
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // PC source selects
    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // FSM states; the encoding is exported on state_dbg
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    // Instruction class latched in DECODE
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ADDI   = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6
    } instr_class_t;

    // R-type function to ALU operation. Returns {illegal, alu_op}.
    function automatic logic [3:0] rtype_alu_op(input logic [2:0] fn);
        logic [3:0] res_s;
        case (fn)
            3'b000:  res_s = {1'b0, 3'b000};
            3'b010:  res_s = {1'b0, 3'b001};
            3'b100:  res_s = {1'b0, 3'b010};
            3'b101:  res_s = {1'b0, 3'b011};
            3'b001:  res_s = {1'b0, 3'b100};
            3'b011:  res_s = {1'b0, 3'b101};
            3'b111:  res_s = {1'b0, 3'b110};
            default: res_s = {1'b1, 3'b000};  // FN_ILLEGAL
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   opcode      - IR opcode field
//   func        - IR R-type function field (low three bits select the ALU op)
//   instr_class - decoded instruction class (CLS_NONE when illegal)
//   alu_op      - ALU operation the instruction uses in EXECUTE/WRITEBACK
//   illegal     - opcode or R-type function has no defined meaning
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 3,
    parameter int ALUCTL_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    output instr_class_t        instr_class,
    output logic [ALUCTL_W-1:0] alu_op,
    output logic                illegal
);

    logic [3:0] rtype_s;

    // Opcode/function decode into class, ALU operation and illegal flag
    always_comb begin
        rtype_s     = rtype_alu_op(3'(func));
        instr_class = CLS_NONE;
        alu_op      = ALUCTL_W'(ALU_ADD);
        illegal     = 1'b0;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                if (rtype_s[3]) begin
                    illegal = 1'b1;
                end else begin
                    instr_class = CLS_RTYPE;
                    alu_op      = ALUCTL_W'(rtype_s[2:0]);
                end
            end
            OPCODE_W'(OP_ADDI):   instr_class = CLS_ADDI;
            OPCODE_W'(OP_LOAD):   instr_class = CLS_LOAD;
            OPCODE_W'(OP_STORE):  instr_class = CLS_STORE;
            OPCODE_W'(OP_BRANCH): begin
                instr_class = CLS_BRANCH;
                alu_op      = ALUCTL_W'(ALU_CMP);
            end
            OPCODE_W'(OP_JUMP):   instr_class = CLS_JUMP;
            default:              illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH, DECODE,
// EXECUTE, MEM and WRITEBACK, handshakes with variable-latency instruction and
// data memories, and traps on illegal instructions and memory timeouts.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   run                 - allow a new fetch
//   opcode, func        - IR fields (valid from DECODE onward)
//   alu_zero            - ALU zero flag, steers the branch PC select
//   imem_ready          - instruction word available
//   dmem_ready          - data access complete
//   imem_req, ir_write  - fetch request / IR load
//   pc_write, pc_src    - PC update and source (00 pc+1, 01 branch, 10 jump)
//   reg_write, mem_to_reg, alu_src, alu_control, r2_chooser - datapath controls
//   mem_read, mem_write - data memory requests
//   illegal_instr, bus_error - sticky trap causes, cleared only by reset
//   state_dbg           - current FSM state encoding
// Control outputs are decoded from the registered state, the latched class and
// ALU op; only ir_write, branch pc_src and the STORE completion PC update also
// look at the same-cycle ready/zero inputs.
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int FUNC_W      = 3,
    parameter int ALUCTL_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                alu_zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                alu_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                r2_chooser,
    output logic                illegal_instr,
    output logic                bus_error,
    output logic [2:0]          state_dbg
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              state_r;
    instr_class_t        class_r;
    logic [ALUCTL_W-1:0] alu_op_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic                illegal_r;
    logic                bus_error_r;

    instr_class_t        dec_class_s;
    logic [ALUCTL_W-1:0] dec_alu_op_s;
    logic                dec_illegal_s;
    logic                wait_active_s;
    logic                wait_ready_s;
    logic                timeout_s;

    instr_decoder #(
        .OPCODE_W (OPCODE_W),
        .FUNC_W   (FUNC_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_decoder (
        .opcode      (opcode),
        .func        (func),
        .instr_class (dec_class_s),
        .alu_op      (dec_alu_op_s),
        .illegal     (dec_illegal_s)
    );

    // Memory wait qualification: a FETCH with run pending or any MEM cycle
    // is a wait cycle; the timeout fires when the count has already reached
    // MEM_TIMEOUT and ready is still low, so ready on that cycle still wins.
    always_comb begin
        wait_active_s = 1'b0;
        wait_ready_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                wait_active_s = run;
                wait_ready_s  = imem_ready;
            end
            ST_MEM: begin
                wait_active_s = 1'b1;
                wait_ready_s  = dmem_ready;
            end
            default: begin
                wait_active_s = 1'b0;
                wait_ready_s  = 1'b0;
            end
        endcase
        timeout_s = wait_active_s && !wait_ready_s && (wait_cnt_r == TIMEOUT_C);
    end

    // FSM state, latched instruction, wait counter and sticky trap flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            class_r     <= CLS_NONE;
            alu_op_r    <= {ALUCTL_W{1'b0}};
            wait_cnt_r  <= CNT_ZERO;
            illegal_r   <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (run && imem_ready) begin
                        state_r    <= ST_DECODE;
                        wait_cnt_r <= CNT_ZERO;
                    end else if (timeout_s) begin
                        state_r     <= ST_TRAP;
                        bus_error_r <= 1'b1;
                        wait_cnt_r  <= CNT_ZERO;
                    end else if (run) begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end else begin
                        // stalled by run=0: count is frozen, not cleared
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                ST_DECODE: begin
                    wait_cnt_r <= CNT_ZERO;
                    if (dec_illegal_s) begin
                        state_r   <= ST_TRAP;
                        illegal_r <= 1'b1;
                    end else begin
                        state_r  <= ST_EXECUTE;
                        class_r  <= dec_class_s;
                        alu_op_r <= dec_alu_op_s;
                    end
                end
                ST_EXECUTE: begin
                    wait_cnt_r <= CNT_ZERO;
                    case (class_r)
                        CLS_RTYPE, CLS_ADDI:  state_r <= ST_WRITEBACK;
                        CLS_LOAD, CLS_STORE:  state_r <= ST_MEM;
                        CLS_BRANCH, CLS_JUMP: state_r <= ST_FETCH;
                        default: begin
                            state_r   <= ST_TRAP;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt_r <= CNT_ZERO;
                        if (class_r == CLS_LOAD) begin
                            state_r <= ST_WRITEBACK;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else if (timeout_s) begin
                        state_r     <= ST_TRAP;
                        bus_error_r <= 1'b1;
                        wait_cnt_r  <= CNT_ZERO;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_WRITEBACK: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= CNT_ZERO;
                end
                ST_TRAP: begin
                    state_r    <= ST_TRAP;
                    wait_cnt_r <= CNT_ZERO;
                end
                default: begin
                    state_r    <= ST_TRAP;
                    wait_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Datapath control decode; anything not set for a state stays 0
    always_comb begin
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_NEXT;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        alu_control = {ALUCTL_W{1'b0}};
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        r2_chooser  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req = run;
                ir_write = run && imem_ready;
            end
            ST_EXECUTE: begin
                case (class_r)
                    CLS_RTYPE: begin
                        alu_control = alu_op_r;
                    end
                    CLS_ADDI: begin
                        alu_src     = 1'b1;
                        alu_control = alu_op_r;
                    end
                    CLS_LOAD: begin
                        alu_src     = 1'b1;
                        alu_control = ALUCTL_W'(ALU_ADD);
                    end
                    CLS_STORE: begin
                        alu_src     = 1'b1;
                        alu_control = ALUCTL_W'(ALU_ADD);
                        r2_chooser  = 1'b1;
                    end
                    CLS_BRANCH: begin
                        alu_control = ALUCTL_W'(ALU_CMP);
                        r2_chooser  = 1'b1;
                        pc_write    = 1'b1;
                        if (alu_zero) begin
                            pc_src = PC_BRANCH;
                        end else begin
                            pc_src = PC_NEXT;
                        end
                    end
                    CLS_JUMP: begin
                        alu_src  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                    default: begin
                        alu_src = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                if (class_r == CLS_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    // STORE retires here, so the PC advances on completion
                    mem_write = 1'b1;
                    pc_write  = dmem_ready;
                end
            end
            ST_WRITEBACK: begin
                reg_write   = 1'b1;
                pc_write    = 1'b1;
                mem_to_reg  = (class_r == CLS_LOAD);
                alu_src     = (class_r != CLS_RTYPE);
                alu_control = alu_op_r;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign illegal_instr = illegal_r;
    assign bus_error     = bus_error_r;
    assign state_dbg     = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one linear sequence of steps,
// each output vector compared against a hand-computed expectation.
module tb_multicycle_control_unit;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [2:0] SF = 3'd0;  // FETCH
    localparam logic [2:0] SD = 3'd1;  // DECODE
    localparam logic [2:0] SE = 3'd2;  // EXECUTE
    localparam logic [2:0] SM = 3'd3;  // MEM
    localparam logic [2:0] SW = 3'd4;  // WRITEBACK
    localparam logic [2:0] ST = 3'd5;  // TRAP

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic [2:0] func;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_control;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       r2_chooser;
    logic       illegal_instr;
    logic       bus_error;
    logic [2:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] fn_tab [7] = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b001, 3'b011, 3'b111};
    logic [2:0] op_tab [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

    multicycle_control_unit #(
        .OPCODE_W    (4),
        .FUNC_W      (3),
        .ALUCTL_W    (3),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .func          (func),
        .alu_zero      (alu_zero),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .alu_src       (alu_src),
        .alu_control   (alu_control),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .r2_chooser    (r2_chooser),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .state_dbg     (state_dbg)
    );

    logic [18:0] obs;
    assign obs = {state_dbg, imem_req, ir_write, pc_write, pc_src, reg_write, alu_src,
                  alu_control, mem_read, mem_write, mem_to_reg, r2_chooser,
                  illegal_instr, bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input logic [2:0] st, input logic ireq, input logic irw,
                                       input logic pcw, input logic [1:0] pcs, input logic rw,
                                       input logic asrc, input logic [2:0] actl, input logic mr,
                                       input logic mw, input logic m2r, input logic r2,
                                       input logic ill, input logic be);
        return {st, ireq, irw, pcw, pcs, rw, asrc, actl, mr, mw, m2r, r2, ill, be};
    endfunction

    function automatic logic [18:0] idle(input logic [2:0] st);
        return mk(st, N, N, N, 2'b00, N, N, 3'b000, N, N, N, N, N, N);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [18:0] exp);
        #2;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called in a FETCH cycle: fetch with zero wait, pass DECODE, end in EXECUTE
    task automatic fetch_now(input logic [3:0] op, input logic [2:0] fn);
        run        = Y;
        imem_ready = Y;
        opcode     = op;
        func       = fn;
        chk("fetch", mk(SF, Y, Y, N, 2'b00, N, N, 3'b000, N, N, N, N, N, N));
        cyc();
        run        = N;
        imem_ready = N;
        chk("decode", idle(SD));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = Y; run = N; opcode = 4'b0000; func = 3'b000;
        alu_zero = N; imem_ready = N; dmem_ready = N;
        cyc();
        cyc();
        reset = N;
        chk("reset", idle(SF));

        // R-type: every function code, 4-cycle latency
        for (int i = 0; i < 7; i++) begin
            chk("r_idle", idle(SF));
            fetch_now(4'b0000, fn_tab[i]);
            chk("r_exec", mk(SE, N, N, N, 2'b00, N, N, op_tab[i], N, N, N, N, N, N));
            cyc();
            chk("r_wb", mk(SW, N, N, Y, 2'b00, Y, N, op_tab[i], N, N, N, N, N, N));
            cyc();
        end
        chk("r_done", idle(SF));

        // ADDI
        fetch_now(4'b0100, 3'b000);
        chk("addi_exec", mk(SE, N, N, N, 2'b00, N, Y, 3'b000, N, N, N, N, N, N));
        cyc();
        chk("addi_wb", mk(SW, N, N, Y, 2'b00, Y, Y, 3'b000, N, N, N, N, N, N));
        cyc();

        // LOAD with dmem_ready three cycles late: mem_read for 4 cycles
        fetch_now(4'b1011, 3'b000);
        chk("load_exec", mk(SE, N, N, N, 2'b00, N, Y, 3'b000, N, N, N, N, N, N));
        cyc();
        for (int i = 0; i < 3; i++) begin
            dmem_ready = N;
            chk("load_mem_wait", mk(SM, N, N, N, 2'b00, N, N, 3'b000, Y, N, N, N, N, N));
            cyc();
        end
        dmem_ready = Y;
        chk("load_mem_ready", mk(SM, N, N, N, 2'b00, N, N, 3'b000, Y, N, N, N, N, N));
        cyc();
        dmem_ready = N;
        chk("load_wb", mk(SW, N, N, Y, 2'b00, Y, Y, 3'b000, N, N, Y, N, N, N));
        cyc();
        chk("load_done", idle(SF));

        // BRANCH taken then not taken
        fetch_now(4'b1000, 3'b000);
        alu_zero = Y;
        chk("br_taken", mk(SE, N, N, Y, 2'b01, N, N, 3'b111, N, N, N, Y, N, N));
        cyc();
        alu_zero = N;
        chk("br_taken_done", idle(SF));
        fetch_now(4'b1000, 3'b000);
        chk("br_not_taken", mk(SE, N, N, Y, 2'b00, N, N, 3'b111, N, N, N, Y, N, N));
        cyc();
        chk("br_not_taken_done", idle(SF));

        // JUMP
        fetch_now(4'b0010, 3'b000);
        chk("jump_exec", mk(SE, N, N, Y, 2'b10, N, Y, 3'b000, N, N, N, N, N, N));
        cyc();
        chk("jump_done", idle(SF));

        // STORE, zero wait
        fetch_now(4'b1111, 3'b000);
        chk("st_exec", mk(SE, N, N, N, 2'b00, N, Y, 3'b000, N, N, N, Y, N, N));
        cyc();
        dmem_ready = Y;
        chk("st_mem_ready", mk(SM, N, N, Y, 2'b00, N, N, 3'b000, N, Y, N, N, N, N));
        cyc();
        dmem_ready = N;
        chk("st_done", idle(SF));

        // STORE with ready on the cycle the count equals MEM_TIMEOUT: no error
        fetch_now(4'b1111, 3'b000);
        cyc();
        for (int i = 0; i < 15; i++) begin
            dmem_ready = N;
            chk("st_late_wait", mk(SM, N, N, N, 2'b00, N, N, 3'b000, N, Y, N, N, N, N));
            cyc();
        end
        dmem_ready = Y;
        chk("st_late_ready", mk(SM, N, N, Y, 2'b00, N, N, 3'b000, N, Y, N, N, N, N));
        cyc();
        dmem_ready = N;
        chk("st_late_done", idle(SF));

        // Fetch waits: 10 counted, 20 paused by run=0, 5 counted, ready at 15
        run = Y;
        imem_ready = N;
        for (int i = 0; i < 10; i++) begin
            chk("fetch_wait", mk(SF, Y, N, N, 2'b00, N, N, 3'b000, N, N, N, N, N, N));
            cyc();
        end
        run = N;
        chk("fetch_paused", idle(SF));
        for (int i = 0; i < 20; i++) begin
            cyc();
        end
        run = Y;
        for (int i = 0; i < 5; i++) begin
            chk("fetch_wait2", mk(SF, Y, N, N, 2'b00, N, N, 3'b000, N, N, N, N, N, N));
            cyc();
        end

        // Illegal opcode 0101 fetched on that boundary cycle
        fetch_now(4'b0101, 3'b000);
        chk("illegal_op", mk(ST, N, N, N, 2'b00, N, N, 3'b000, N, N, N, N, Y, N));
        run = Y;
        imem_ready = Y;
        cyc();
        chk("illegal_hold", mk(ST, N, N, N, 2'b00, N, N, 3'b000, N, N, N, N, Y, N));
        reset = Y;
        cyc();
        reset = N;
        run = N;
        imem_ready = N;
        chk("illegal_cleared", idle(SF));

        // Illegal R-type function 110
        fetch_now(4'b0000, 3'b110);
        chk("illegal_func", mk(ST, N, N, N, 2'b00, N, N, 3'b000, N, N, N, N, Y, N));
        reset = Y;
        cyc();
        reset = N;
        chk("illegal_func_cleared", idle(SF));

        // STORE with dmem_ready never arriving: bus error
        fetch_now(4'b1111, 3'b000);
        cyc();
        for (int i = 0; i < 16; i++) begin
            dmem_ready = N;
            chk("st_timeout_wait", mk(SM, N, N, N, 2'b00, N, N, 3'b000, N, Y, N, N, N, N));
            cyc();
        end
        chk("bus_error", mk(ST, N, N, N, 2'b00, N, N, 3'b000, N, N, N, N, N, Y));
        dmem_ready = Y;
        cyc();
        dmem_ready = N;
        chk("bus_error_hold", mk(ST, N, N, N, 2'b00, N, N, 3'b000, N, N, N, N, N, Y));
        reset = Y;
        cyc();
        reset = N;
        chk("bus_error_cleared", idle(SF));

        // Reset during MEM of a STORE aborts it
        fetch_now(4'b1111, 3'b000);
        cyc();
        chk("st_mem_pre_reset", mk(SM, N, N, N, 2'b00, N, N, 3'b000, N, Y, N, N, N, N));
        reset = Y;
        cyc();
        reset = N;
        chk("reset_mid_store", idle(SF));
        cyc();
        chk("post_reset_idle", idle(SF));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle decoder of the 8-bit processor. An FSM sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and handshakes with instruction and data memories that have variable latency. It drives every datapath enable (PC, IR, register file, ALU, memory) and traps on illegal opcodes and memory timeouts. It sits between the instruction register and the datapath muxes.

Parameters:
OPCODE_W, 4, opcode field width
FUNC_W, 3, R-type function field width
ALUCTL_W, 3, ALU control width
MEM_TIMEOUT, 15, max wait cycles for imem_ready/dmem_ready before bus error (≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  allow a new fetch
opcode  in  OPCODE_W  IR opcode field (valid from DECODE onward)
func  in  FUNC_W  IR function field
alu_zero  in  1  ALU zero flag
imem_ready  in  1  instruction word available
dmem_ready  in  1  data access complete
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  2  00 pc+1, 01 branch target, 10 jump target
reg_write  out  1  register file write
alu_src  out  1  0 register, 1 immediate
alu_control  out  ALUCTL_W  ALU operation
mem_read  out  1  data read request
mem_write  out  1  data write request
mem_to_reg  out  1  writeback select memory
r2_chooser  out  1  second read-port select
illegal_instr  out  1  sticky trap flag
bus_error  out  1  sticky timeout flag
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset: state = FETCH. All outputs 0, including the sticky flags and wait counter. A reset mid-instruction aborts it with no pending write.
- Outputs are Moore functions of the state, the latched instruction class and alu_zero. Any output not listed for a state is 0.
- FETCH: imem_req=run. On run & imem_ready: ir_write=1 that cycle, go to DECODE.
- DECODE: latch class and alu op from opcode/func.
  - opcode 0000: R-type. func→alu: 000→000, 010→001, 100→010, 101→011, 001→100, 011→101, 111→110. func 110 is illegal.
  - 0100 ADDI, 1011 LOAD, 1111 STORE, 1000 BRANCH, 0010 JUMP.
  - Any other opcode is illegal: go to TRAP.
- EXECUTE:
  - R-type: alu_src=0. Go to WRITEBACK.
  - ADDI: alu_src=1. Go to WRITEBACK.
  - LOAD/STORE: alu_src=1, alu_control=000. STORE also r2_chooser=1. Go to MEM.
  - BRANCH: alu_control=111, r2_chooser=1, pc_write=1, pc_src=alu_zero?01:00. Go to FETCH.
  - JUMP: alu_src=1, pc_write=1, pc_src=10. Go to FETCH.
- MEM:
  - LOAD: mem_read=1 held until dmem_ready, then go to WRITEBACK.
  - STORE: mem_write=1 held until dmem_ready. In the dmem_ready cycle also pc_write=1, pc_src=00, then go to FETCH.
- WRITEBACK: reg_write=1, pc_write=1, pc_src=00, mem_to_reg=(LOAD). alu_control and alu_src hold the EXECUTE values. Go to FETCH.
- Latency with zero-wait memories:
  - R/ADDI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/JUMP: 3 cycles.
- Wait counter:
  - Counts consecutive FETCH-with-run or MEM cycles without ready. Cleared on ready or on state change.
  - If the counter reaches MEM_TIMEOUT in the same cycle ready is still low: bus_error=1, go to TRAP.
  - Ready arriving on the cycle count==MEM_TIMEOUT wins (no error).
- TRAP: all enables 0. illegal_instr or bus_error is held. The FSM leaves TRAP only on reset.
- run=0 in FETCH: the FSM stays in FETCH with imem_req=0 and the counter does not advance. run has no effect in other states.

Decomposition:
- Shared package cpu_pkg: opcode localparams, func codes, ALU op codes, pc_src codes, state enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP), instruction-class enum.
- One sub-module: instr_decoder (combinational opcode/func → class, alu op, illegal).

Test Plan:
- R-type add (opcode 0000, func 000), zero-wait memories → cycle 1 imem_req, 2 DECODE, 3 alu_control=000, 4 reg_write=1 with pc_write=1; back in FETCH at cycle 5.
- LOAD (1011) with dmem_ready delayed 3 cycles → mem_read high exactly 4 cycles, then one WRITEBACK cycle with mem_to_reg=1, reg_write=1.
- BRANCH (1000), alu_zero=1 then alu_zero=0 → pc_src=01 then pc_src=00. Each takes 3 cycles; reg_write stays 0 throughout.
- Opcode 0101, and opcode 0000 with func 110 → TRAP, illegal_instr=1, no reg_write/mem_write. Cleared only after reset asserted 1 cycle.
- STORE with dmem_ready never asserted, MEM_TIMEOUT=15 → bus_error=1 after 15 wait cycles, mem_write then 0. Separate run with ready at the 15th cycle → no error.
- Reset asserted during MEM of a STORE → next cycle state_dbg=FETCH, all outputs 0.
